// File: rtl/cs_rx_assembler.sv
// cs_rx_assembler: receive-side frame assembler for the CS-FEC decoder.
// Gathers out-of-order coded symbols into a K-slot frame, marks missing
// slots as erasures and emits the frame in a single-cycle pulse on
// completion, tag change or timeout.
// Optional feature macro: CS_RX_DUP_CHECK_EN (drop duplicate indices
// instead of last-write-wins).
module cs_rx_assembler #(
  parameter int M       = 2,
  parameter int K       = 3,
  parameter int WIDTH   = 4,
  parameter int SEQ_W   = 8,
  parameter int TIMEOUT = 16,
  parameter int IDXW    = (K > 1) ? $clog2(K) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sym_valid,
  input  logic [IDXW-1:0]    sym_idx,
  input  logic [SEQ_W-1:0]   sym_seq,
  input  logic [WIDTH-1:0]   sym_data,
  output logic               out_valid,
  output logic [K-1:0]       out_erasure,
  output logic [WIDTH-1:0]   out_coded [K],
  output logic [SEQ_W-1:0]   out_seq,
  output logic               out_short,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        drop_cnt
);

  // Timer holds the frame age in cycles, where the cycle of the first
  // symbol is age 0. The register is loaded with the age of the *next*
  // cycle, so a frame whose first symbol arrives in cycle t reaches
  // age TIMEOUT-1 in cycle t+TIMEOUT-1 and pulses in cycle t+TIMEOUT.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t             state_reg, state_next;
  logic [K-1:0]       mask_reg, mask_next, mask_eff;
  logic [WIDTH-1:0]   frame_buf_reg [K];
  logic [WIDTH-1:0]   eff_data [K];
  logic [SEQ_W-1:0]   cur_seq_reg, cur_seq_next;
  logic [SEQ_W-1:0]   last_seq_reg;
  logic               last_valid_reg;
  logic [TW-1:0]      tmr_reg, tmr_next;

  logic               idx_ok;
  logic [K-1:0]       sym_onehot;
  logic               dup_drop;
  logic               wr_en;
  logic               drop;
  logic               flush;
  logic               flush_old;
  logic [K-1:0]       flush_mask;
  logic [SEQ_W-1:0]   flush_seq;

  function automatic int popcount(input logic [K-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < K; i++) n += int'(v[i]);
    return n;
  endfunction

  assign idx_ok = (32'(sym_idx) < K);

  // One-hot decode of the incoming index and the buffer view with this
  // cycle's write already applied (used by completion/timeout flushes).
  for (genvar gi = 0; gi < K; gi++) begin : g_slot
    assign sym_onehot[gi] = (32'(sym_idx) == gi);
    assign eff_data[gi]   = (wr_en && sym_onehot[gi]) ? sym_data : frame_buf_reg[gi];
  end

`ifdef CS_RX_DUP_CHECK_EN
  assign dup_drop = |(mask_reg & sym_onehot);
`else
  assign dup_drop = 1'b0;
`endif

  // Next-state, accept/drop and flush decisions.
  always_comb begin
    state_next   = state_reg;
    mask_next    = mask_reg;
    mask_eff     = mask_reg;
    cur_seq_next = cur_seq_reg;
    tmr_next     = tmr_reg;
    wr_en        = 1'b0;
    drop         = 1'b0;
    flush        = 1'b0;
    flush_old    = 1'b0;
    flush_mask   = mask_reg;
    flush_seq    = cur_seq_reg;
    case (state_reg)
      IDLE: begin
        if (sym_valid) begin
          if (!idx_ok || (last_valid_reg && sym_seq == last_seq_reg)) begin
            drop = 1'b1;
          end else begin
            wr_en        = 1'b1;
            mask_next    = sym_onehot;
            cur_seq_next = sym_seq;
            tmr_next     = TW'(1);
            state_next   = COLLECT;
            // A single symbol can already complete or expire a frame
            // for degenerate K or TIMEOUT of 1.
            if ((&sym_onehot) || (TIMEOUT == 1)) begin
              flush      = 1'b1;
              flush_mask = sym_onehot;
              flush_seq  = sym_seq;
              state_next = IDLE;
            end
          end
        end
      end
      COLLECT: begin
        if (sym_valid && idx_ok && sym_seq != cur_seq_reg) begin
          // New tag: emit the held frame from the old buffer contents and
          // start the new one in the same cycle.
          flush        = 1'b1;
          flush_old    = 1'b1;
          wr_en        = 1'b1;
          mask_next    = sym_onehot;
          cur_seq_next = sym_seq;
          tmr_next     = TW'(1);
        end else begin
          if (sym_valid) begin
            if (!idx_ok || dup_drop) begin
              drop = 1'b1;
            end else begin
              wr_en    = 1'b1;
              mask_eff = mask_reg | sym_onehot;
            end
          end
          mask_next = mask_eff;
          if ((&mask_eff) || (tmr_reg == TMR_LAST)) begin
            flush      = 1'b1;
            flush_mask = mask_eff;
            state_next = IDLE;
          end else begin
            tmr_next = tmr_reg + TW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame state, history and saturating counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      mask_reg       <= '0;
      cur_seq_reg    <= '0;
      tmr_reg        <= '0;
      last_seq_reg   <= '0;
      last_valid_reg <= 1'b0;
      out_valid      <= 1'b0;
      out_erasure    <= '0;
      out_seq        <= '0;
      out_short      <= 1'b0;
      frame_cnt      <= '0;
      drop_cnt       <= '0;
    end else begin
      state_reg   <= state_next;
      mask_reg    <= mask_next;
      cur_seq_reg <= cur_seq_next;
      tmr_reg     <= tmr_next;
      out_valid   <= flush;
      if (flush) begin
        out_erasure    <= ~flush_mask;
        out_seq        <= flush_seq;
        out_short      <= (popcount(flush_mask) < M);
        last_seq_reg   <= flush_seq;
        last_valid_reg <= 1'b1;
        if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
      end
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Per-slot symbol storage and registered coded output with erased
  // slots forced to zero.
  for (genvar gi = 0; gi < K; gi++) begin : g_out
    always_ff @(posedge clk) begin
      if (wr_en && sym_onehot[gi]) frame_buf_reg[gi] <= sym_data;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_coded[gi] <= '0;
      end else if (flush) begin
        if (!flush_mask[gi])
          out_coded[gi] <= '0;
        else if (flush_old)
          out_coded[gi] <= frame_buf_reg[gi];
        else
          out_coded[gi] <= eff_data[gi];
      end
    end
  end

endmodule
